// File: rtl/tdc_spi_reader.sv
// tdc_spi_reader
// SPI master that drains a TDC capture buffer over the flash-pin serial link.
// It frames a read with FLASH_SSB and generates FLASH_SCK. After discarding
// LEAD_BITS lead bits, it assembles WORD_BITS-wide MSB-first words from
// FLASH_MISO and hands them out on a valid/ready stream. While the consumer
// still holds the previous word, SCK is frozen low at the word boundary.
//
// Optional build macro: TDC_READER_SYNC_EN
//   When defined, FLASH_MISO passes through a two-flop synchronizer and each
//   bit is taken two CLK cycles after its SCK falling edge. Needs SCK_DIV >= 3.
module tdc_spi_reader #(
   parameter int WORD_BITS = 32,
   parameter int SCK_DIV   = 4,
   parameter int LEAD_BITS = 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 START,
   input  logic [8:0]           NUM_WORDS,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 FLASH_SCK,
   output logic                 FLASH_SSB,
   input  logic                 FLASH_MISO,
   output logic [WORD_BITS-1:0] WORD_DATA,
   output logic                 WORD_VALID,
   input  logic                 WORD_READY
);

   localparam int DIV_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int BIT_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam int LEAD_W = (LEAD_BITS > 0) ? $clog2(LEAD_BITS + 1) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_STALL,
      ST_TRAIL,
      ST_FIN
   } state_t;

   state_t               state;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [LEAD_W-1:0]    lead_rem;
   logic [8:0]           word_cnt;
   logic [8:0]           word_target;
   logic [WORD_BITS-1:0] shift_reg;
   logic                 pending;

   logic                 div_last;
   logic                 fall_now;
   logic                 bits_left;
   logic                 load_now;
   logic                 handshake;
   logic                 start_ok;
   logic [8:0]           num_clamped;
   logic                 sample_now;
   logic                 sample_bit;

   // Phase timing, frame progress and stream bookkeeping decoded from state
   always_comb begin
      div_last    = 1'b0;
      fall_now    = 1'b0;
      bits_left   = 1'b0;
      load_now    = 1'b0;
      handshake   = 1'b0;
      start_ok    = 1'b0;
      num_clamped = NUM_WORDS;
      div_last    = (div_cnt == DIV_W'(SCK_DIV - 1));
      fall_now    = (state == ST_HIGH) && div_last;
      bits_left   = (lead_rem != '0) || (word_cnt != word_target);
      load_now    = pending && !WORD_VALID;
      handshake   = WORD_VALID && WORD_READY;
      start_ok    = (state == ST_IDLE) && START && (!WORD_VALID || WORD_READY);
      if (NUM_WORDS > 9'd256) begin
         num_clamped = 9'd256;
      end
   end

`ifdef TDC_READER_SYNC_EN
   logic miso_s1;
   logic miso_s2;
   logic fall_d1;
   logic fall_d2;

   // Resynchronise MISO and delay the sample strobe by the same two cycles
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         miso_s1 <= 1'b0;
         miso_s2 <= 1'b0;
         fall_d1 <= 1'b0;
         fall_d2 <= 1'b0;
      end else begin
         miso_s1 <= FLASH_MISO;
         miso_s2 <= miso_s1;
         fall_d1 <= fall_now;
         fall_d2 <= fall_d1;
      end
   end

   assign sample_now = fall_d2;
   assign sample_bit = miso_s2;
`else
   assign sample_now = fall_now;
   assign sample_bit = FLASH_MISO;
`endif

   // Frame sequencer: SSB/SCK generation, bit/word counting and the holding register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= ST_IDLE;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         lead_rem    <= '0;
         word_cnt    <= '0;
         word_target <= '0;
         shift_reg   <= '0;
         pending     <= 1'b0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         FLASH_SCK   <= 1'b0;
         FLASH_SSB   <= 1'b1;
         WORD_DATA   <= '0;
         WORD_VALID  <= 1'b0;
      end else begin
         DONE <= 1'b0;

         if (handshake) begin
            WORD_VALID <= 1'b0;
         end
         if (load_now) begin
            WORD_DATA  <= shift_reg;
            WORD_VALID <= 1'b1;
            pending    <= 1'b0;
         end

         if (sample_now) begin
            if (lead_rem != '0) begin
               lead_rem <= lead_rem - LEAD_W'(1);
            end else begin
               shift_reg <= {shift_reg[WORD_BITS-2:0], sample_bit};
               if (bit_cnt == BIT_W'(WORD_BITS - 1)) begin
                  bit_cnt  <= '0;
                  word_cnt <= word_cnt + 9'd1;
                  pending  <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
         end

         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  word_target <= num_clamped;
                  word_cnt    <= '0;
                  bit_cnt     <= '0;
                  lead_rem    <= LEAD_W'(LEAD_BITS);
                  div_cnt     <= '0;
                  BUSY        <= 1'b1;
                  if (num_clamped == 9'd0) begin
                     state <= ST_FIN;
                     DONE  <= 1'b1;
                  end else begin
                     state     <= ST_SETUP;
                     FLASH_SSB <= 1'b0;
                  end
               end
            end
            ST_SETUP: begin
               if (div_last) begin
                  div_cnt   <= '0;
                  state     <= ST_HIGH;
                  FLASH_SCK <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            ST_HIGH: begin
               if (div_last) begin
                  div_cnt   <= '0;
                  state     <= ST_LOW;
                  FLASH_SCK <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            ST_LOW: begin
               if (div_last) begin
                  div_cnt <= '0;
                  if (pending && WORD_VALID) begin
                     state <= ST_STALL;
                  end else if (bits_left) begin
                     state     <= ST_HIGH;
                     FLASH_SCK <= 1'b1;
                  end else begin
                     state <= ST_TRAIL;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            ST_STALL: begin
               if (!WORD_VALID) begin
                  div_cnt <= '0;
                  if (bits_left) begin
                     state     <= ST_HIGH;
                     FLASH_SCK <= 1'b1;
                  end else begin
                     state <= ST_TRAIL;
                  end
               end
            end
            ST_TRAIL: begin
               if (div_last) begin
                  div_cnt   <= '0;
                  state     <= ST_FIN;
                  FLASH_SSB <= 1'b1;
                  DONE      <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_spi_reader.sv
// tb_tdc_spi_reader
// Self-checking bench for tdc_spi_reader. A responder model shifts a queued
// bit stream onto FLASH_MISO after every SCK rise. Expected words go into a
// scoreboard queue when a frame is set up and are popped on each handshake.
`timescale 1ns/1ps
module tb_tdc_spi_reader;

   localparam int SD = 3;
   localparam int LB = 1;
   localparam int WB = 32;

   logic        CLK        = 1'b0;
   logic        RST_N      = 1'b0;
   logic        START      = 1'b0;
   logic [8:0]  NUM_WORDS  = 9'd0;
   logic        FLASH_MISO = 1'b0;
   logic        WORD_READY = 1'b0;
   logic        BUSY;
   logic        DONE;
   logic        FLASH_SCK;
   logic        FLASH_SSB;
   logic [31:0] WORD_DATA;
   logic        WORD_VALID;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int sckRises, ssbFalls, handshakes, gapErr, doneCount;
   int lastRise, lastFallCyc, ssbFallCyc, doneCyc, firstValidCyc, startCyc;
   bit doneSeen;
   logic prevSck   = 1'b0;
   logic prevSsb   = 1'b1;
   logic prevValid = 1'b0;

   logic [31:0] expQ[$];
   logic        respBits[$];

   tdc_spi_reader #(
      .WORD_BITS(WB),
      .SCK_DIV  (SD),
      .LEAD_BITS(LB)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .START     (START),
      .NUM_WORDS (NUM_WORDS),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .FLASH_SCK (FLASH_SCK),
      .FLASH_SSB (FLASH_SSB),
      .FLASH_MISO(FLASH_MISO),
      .WORD_DATA (WORD_DATA),
      .WORD_VALID(WORD_VALID),
      .WORD_READY(WORD_READY)
   );

   // Free-running system clock
   always #5 CLK = ~CLK;

   // Responder: present the next queued bit after every SCK rise
   always @(posedge FLASH_SCK) begin
      if (respBits.size() != 0) begin
         FLASH_MISO = respBits.pop_front();
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Link monitor and scoreboard, sampled on the falling CLK edge
   always @(negedge CLK) begin
      logic [31:0] expWord;
      cyc++;
      if (FLASH_SCK && !prevSck) begin
         sckRises++;
         if (lastRise >= 0 && (cyc - lastRise) != 2 * SD) gapErr++;
         lastRise = cyc;
      end
      if (!FLASH_SCK && prevSck) lastFallCyc = cyc;
      if (!FLASH_SSB && prevSsb) begin
         ssbFalls++;
         ssbFallCyc = cyc;
         lastRise   = -1;
      end
      if (DONE) begin
         doneSeen = 1'b1;
         doneCyc  = cyc;
         doneCount++;
      end
      if (WORD_VALID && !prevValid && firstValidCyc < 0) firstValidCyc = cyc;
      if (WORD_VALID && WORD_READY) begin
         handshakes++;
         expWord = 'x;
         if (expQ.size() != 0) expWord = expQ.pop_front();
         checkOutput("scoreboard word", WORD_DATA, expWord);
      end
      prevSck   = FLASH_SCK;
      prevSsb   = FLASH_SSB;
      prevValid = WORD_VALID;
   end

   task automatic clearStats();
      sckRises      = 0;
      ssbFalls      = 0;
      handshakes    = 0;
      gapErr        = 0;
      doneCount     = 0;
      lastRise      = -1;
      lastFallCyc   = -1;
      ssbFallCyc    = -1;
      doneCyc       = -1;
      firstValidCyc = -1;
      doneSeen      = 1'b0;
   endtask

   task automatic loadFrame(input int n, input logic [31:0] first, input logic [31:0] step);
      logic [31:0] w;
      for (int i = 0; i < LB; i++) respBits.push_back(1'b1);
      for (int i = 0; i < n; i++) begin
         w = first + step * 32'(i);
         expQ.push_back(w);
         for (int b = WB - 1; b >= 0; b--) respBits.push_back(w[b]);
      end
   endtask

   task automatic pulseStart(input int n);
      @(posedge CLK);
      #1;
      START     = 1'b1;
      NUM_WORDS = 9'(n);
      @(posedge CLK);
      startCyc = cyc;
      #1;
      START = 1'b0;
   endtask

   task automatic applyStimulus(input int n, input logic [31:0] first, input logic [31:0] step);
      loadFrame(n, first, step);
      pulseStart(n);
   endtask

   task automatic waitDone(input string tag, input int limit);
      for (int i = 0; i < limit && !doneSeen; i++) @(negedge CLK);
      checkOutput({tag, " done seen"}, 32'(doneSeen), 1);
   endtask

   function automatic int frameCycles(input int nWords);
      int bits;
      bits = LB + WB * nWords;
      return SD * (1 + 2 * bits) + SD + 1;
   endfunction

   initial begin
      clearStats();

      // Reset values
      repeat (3) @(negedge CLK);
      checkOutput("reset BUSY", 32'(BUSY), 0);
      checkOutput("reset DONE", 32'(DONE), 0);
      checkOutput("reset SCK", 32'(FLASH_SCK), 0);
      checkOutput("reset SSB", 32'(FLASH_SSB), 1);
      checkOutput("reset VALID", 32'(WORD_VALID), 0);
      checkOutput("reset DATA", WORD_DATA, 0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      // Single word with one lead bit
      $display("[TB] single word frame");
      clearStats();
      WORD_READY = 1'b1;
      applyStimulus(1, 32'h89AB_CDEF, 32'h0);
      waitDone("t1", 2000);
      @(negedge CLK);
      checkOutput("t1 handshakes", handshakes, 1);
      checkOutput("t1 sck rises", sckRises, 33);
      checkOutput("t1 duration", doneCyc - ssbFallCyc + 1, frameCycles(1));
      checkOutput("t1 valid latency", firstValidCyc - lastFallCyc, 1);
      checkOutput("t1 done pulses", doneCount, 1);
      checkOutput("t1 ssb idle", 32'(FLASH_SSB), 1);
      checkOutput("t1 scoreboard empty", expQ.size(), 0);

      // Maximum-length streaming frame
      $display("[TB] 256 word frame");
      clearStats();
      applyStimulus(256, 32'h0000_0000, 32'h0000_0001);
      waitDone("t2", 60000);
      @(negedge CLK);
      checkOutput("t2 handshakes", handshakes, 256);
      checkOutput("t2 sck rises", sckRises, 8193);
      checkOutput("t2 sck gaps", gapErr, 0);
      checkOutput("t2 duration", doneCyc - ssbFallCyc + 1, frameCycles(256));
      checkOutput("t2 scoreboard empty", expQ.size(), 0);

      // Backpressure: consumer stalls long enough for SCK to freeze
      $display("[TB] stalled consumer");
      clearStats();
      WORD_READY = 1'b0;
      applyStimulus(3, 32'hA5A5_0001, 32'h1111_1111);
      for (int i = 0; i < 600 && !WORD_VALID; i++) @(negedge CLK);
      checkOutput("t3 first valid", 32'(WORD_VALID), 1);
      repeat (300) @(negedge CLK);
      checkOutput("t3 rises frozen", sckRises, LB + 2 * WB);
      checkOutput("t3 sck low in stall", 32'(FLASH_SCK), 0);
      checkOutput("t3 ssb low in stall", 32'(FLASH_SSB), 0);
      checkOutput("t3 busy in stall", 32'(BUSY), 1);
      checkOutput("t3 no handshake yet", handshakes, 0);
      @(posedge CLK);
      #1;
      WORD_READY = 1'b1;
      waitDone("t3", 2000);
      @(negedge CLK);
      checkOutput("t3 handshakes", handshakes, 3);
      checkOutput("t3 sck rises", sckRises, LB + 3 * WB);
      checkOutput("t3 scoreboard empty", expQ.size(), 0);

      // Empty frame
      $display("[TB] zero word frame");
      clearStats();
      pulseStart(0);
      waitDone("t4", 10);
      repeat (10) @(negedge CLK);
      checkOutput("t4 done latency", doneCyc - startCyc, 1);
      checkOutput("t4 done pulses", doneCount, 1);
      checkOutput("t4 ssb falls", ssbFalls, 0);
      checkOutput("t4 sck rises", sckRises, 0);

      // Reset in the middle of word 2 of 4
      $display("[TB] reset mid frame");
      clearStats();
      applyStimulus(4, 32'h1234_5678, 32'h0F0F_0F0F);
      for (int i = 0; i < 1000 && sckRises < LB + WB + 12; i++) @(negedge CLK);
      checkOutput("t5 reached word 2", 32'(sckRises >= LB + WB + 12), 1);
      checkOutput("t5 first word delivered", handshakes, 1);
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      checkOutput("t5 async SSB", 32'(FLASH_SSB), 1);
      checkOutput("t5 async SCK", 32'(FLASH_SCK), 0);
      checkOutput("t5 async VALID", 32'(WORD_VALID), 0);
      checkOutput("t5 async DATA", WORD_DATA, 0);
      expQ.delete();
      respBits.delete();
      repeat (3) @(negedge CLK);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
      clearStats();
      applyStimulus(4, 32'hFEDC_BA98, 32'h1357_9BDF);
      waitDone("t5", 2000);
      @(negedge CLK);
      checkOutput("t5 handshakes", handshakes, 4);
      checkOutput("t5 sck rises", sckRises, LB + 4 * WB);
      checkOutput("t5 scoreboard empty", expQ.size(), 0);

      // START ignored while busy and while the last word is still held
      $display("[TB] ignored starts");
      clearStats();
      WORD_READY = 1'b1;
      applyStimulus(2, 32'hDEAD_0000, 32'h0101_0101);
      for (int i = 0; i < 200 && sckRises < 10; i++) @(negedge CLK);
      checkOutput("t6 busy mid frame", 32'(BUSY), 1);
      pulseStart(3);
      repeat (5) @(negedge CLK);
      pulseStart(3);
      for (int i = 0; i < 1000 && handshakes < 1; i++) @(negedge CLK);
      checkOutput("t6 first handshake", handshakes, 1);
      @(posedge CLK);
      #1;
      WORD_READY = 1'b0;
      waitDone("t6", 2000);
      @(negedge CLK);
      checkOutput("t6 single frame", ssbFalls, 1);
      checkOutput("t6 sck rises", sckRises, LB + 2 * WB);
      checkOutput("t6 last word held", 32'(WORD_VALID), 1);
      pulseStart(1);
      repeat (20) @(negedge CLK);
      checkOutput("t6 held start ignored", ssbFalls, 1);
      checkOutput("t6 idle after refusal", 32'(BUSY), 0);
      checkOutput("t6 no extra done", doneCount, 1);
      checkOutput("t6 word still held", 32'(WORD_VALID), 1);
      doneSeen = 1'b0;
      loadFrame(1, 32'h0BAD_F00D, 32'h0);
      @(posedge CLK);
      #1;
      WORD_READY = 1'b1;
      START      = 1'b1;
      NUM_WORDS  = 9'd1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      waitDone("t6 combined", 2000);
      @(negedge CLK);
      checkOutput("t6 combined frame started", ssbFalls, 2);
      checkOutput("t6 combined handshakes", handshakes, 3);
      checkOutput("t6 combined rises", sckRises, 2 * LB + 3 * WB);
      checkOutput("t6 scoreboard empty", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
